pin_verifier: RTL and testbench
===============================

Name: pin_verifier

Overview:
- Upstream stage of the ATM transaction controller.
- Collects keypad digits after card insertion and compares them against the PIN read from the card.
- Counts failed attempts and drives the controller's `pin` input, which must only go high on a correct PIN.
- Retains the card after MAX_TRIES consecutive failures.

Parameters:
- DIGITS, 4: number of BCD digits in a PIN.
- MAX_TRIES, 3: wrong attempts allowed before lock-out; legal range 1..7.
- TRY_W, 3: width of the attempt counter; must satisfy 2^TRY_W > MAX_TRIES.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- cancel  input  1  reset, asynchronous, active-high; clears all state to IDLE.
- card_insert  input  1  level; high while a card is in the slot.
- stored_pin  input  4*DIGITS  PIN from the card; first-entered digit sits in the top nibble.
- key_valid  input  1  one-cycle strobe; key_digit is valid.
- key_digit  input  4  BCD digit 0..9.
- key_enter  input  1  one-cycle strobe; submit the entered digits.
- key_clear  input  1  one-cycle strobe; discard the entered digits.
- pin_ok  output  1  level; high while in VERIFIED; drives the controller's `pin` input.
- pin_fail  output  1  one-cycle pulse per wrong attempt.
- card_retain  output  1  level; high in LOCKED.
- tries_left  output  TRY_W  remaining attempts.
- digit_count  output  3  digits currently buffered, 0..DIGITS; drives the display mask.

Behaviour:
- Reset (cancel=1, asynchronous):
  - state=IDLE, buffer=0, digit_count=0, tries_left=MAX_TRIES.
  - pin_ok=0, pin_fail=0, card_retain=0.
  - Reset takes effect immediately, mid-entry and from LOCKED.
- States: IDLE, COLLECT, CHECK, VERIFIED, FAIL, LOCKED. Encoding comes from the shared package.
- IDLE:
  - card_insert=1 → COLLECT.
  - On that transition: buffer=0, digit_count=0, tries_left=MAX_TRIES.
- COLLECT, per cycle, priority key_clear > key_enter > key_valid:
  - key_clear: buffer=0, digit_count=0, stay in COLLECT.
  - key_enter: → CHECK, regardless of digit_count.
  - key_valid with key_digit<=9 and digit_count<DIGITS: buffer = {buffer[4*DIGITS-5:0], key_digit}; digit_count+1.
  - key_valid with key_digit>9, or with digit_count==DIGITS: ignored, no state change.
- CHECK (exactly 1 cycle):
  - Match means digit_count==DIGITS and buffer==stored_pin.
  - Match → VERIFIED.
  - Mismatch → tries_left-1.
  - If the new tries_left==0 → LOCKED; otherwise → FAIL.
- FAIL (1 cycle): pin_fail=1, buffer=0, digit_count=0, → COLLECT.
- VERIFIED:
  - pin_ok=1 while here.
  - card_insert=0 → IDLE.
- LOCKED:
  - card_retain=1, pin_ok=0.
  - Ignores keypad and card_insert; only cancel exits.
- Card removal: card_insert=0 in COLLECT, CHECK or FAIL → IDLE next edge. No pin_fail pulse, no tries_left decrement.
- Latency: key_enter sampled at edge N → CHECK after N → pin_ok or pin_fail asserted after edge N+1.
- Outputs are registered or decoded from the registered state only; no combinational path from keypad inputs to outputs.
- stored_pin is sampled only in CHECK; it may change at any other time.

Decomposition:
- Shared package atm_pkg:
  - state localparams for this block and for the transaction controller (idle=3'b000 … waiting=3'b101).
  - BCD_MAX=9.
  - DIGIT_W=4.
- One natural sub-module, pin_entry_buffer:
  - shift register and digit counter.
  - inputs: shift_en, clr, digit.
  - outputs: buffer, digit_count, full.
- The FSM and the attempt counter stay in pin_verifier.

Test Plan:
- Correct PIN: stored_pin=16'h1234; insert card; keys 1,2,3,4, enter → pin_ok=1 two edges after enter; tries_left=3; pin_ok drops to 0 one edge after card_insert=0.
- Wrong then right: keys 1,2,3,5, enter → one pin_fail pulse, tries_left=2, digit_count=0; then keys 1,2,3,4, enter → pin_ok=1.
- Lock-out: three wrong entries (9,9,9,9) → pin_fail pulses on tries 1 and 2 only; after try 3 card_retain=1, tries_left=0; then key 1, enter, card_insert=0 → no change; cancel=1 → card_retain=0 asynchronously.
- Short entry and overflow:
  - keys 1,2, enter → counts as a failure (tries_left 3→2).
  - keys 1,2,3,4,5 → digit_count stays 4, buffer=16'h1234.
  - key_digit=4'hA → ignored.
- Simultaneous strobes and clear:
  - keys 1,2, then key_clear+key_valid(7) in the same cycle → digit_count=0, buffer=0.
  - key_enter+key_valid in the same cycle → digit not stored, CHECK entered.
- Abort mid-entry: keys 1,2, then card_insert=0 → IDLE next edge, pin_fail=0; re-insert → tries_left=3, digit_count=0.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared ATM definitions: state encodings for the PIN verifier and the
// transaction controller, plus keypad digit constants.
package atm_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    PV_IDLE     = 3'b000,
    PV_COLLECT  = 3'b001,
    PV_CHECK    = 3'b010,
    PV_VERIFIED = 3'b011,
    PV_FAIL     = 3'b100,
    PV_LOCKED   = 3'b101
  } pv_state_t;

  // Transaction controller states; it consumes pin_ok as its `pin` input.
  localparam logic [2:0] CTRL_IDLE     = 3'b000;
  localparam logic [2:0] CTRL_MENU     = 3'b001;
  localparam logic [2:0] CTRL_BALANCE  = 3'b010;
  localparam logic [2:0] CTRL_WITHDRAW = 3'b011;
  localparam logic [2:0] CTRL_DEPOSIT  = 3'b100;
  localparam logic [2:0] CTRL_WAITING  = 3'b101;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/pin_entry_buffer.sv
// Keypad entry buffer: shifts BCD digits in from the right and counts them,
// saturating at DIGITS.
module pin_entry_buffer
  import atm_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_shift_en,
  input  logic                      i_clr,
  input  logic [DIGIT_W-1:0]        i_digit,
  output logic [DIGIT_W*DIGITS-1:0] o_buffer,
  output logic [2:0]                o_digit_count,
  output logic                      o_full
);

  localparam int unsigned PIN_W = DIGIT_W * DIGITS;

  logic [PIN_W-1:0] r_buffer;
  logic [2:0]       r_count;
  logic             w_full;

  assign w_full = (r_count == 3'(DIGITS));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buffer <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_buffer <= '0;
      r_count  <= '0;
    end else if (i_shift_en && !w_full) begin
      r_buffer <= {r_buffer[PIN_W-DIGIT_W-1:0], i_digit};
      r_count  <= r_count + 3'd1;
    end
  end

  assign o_buffer      = r_buffer;
  assign o_digit_count = r_count;
  assign o_full        = w_full;

endmodule

// File: rtl/pin_verifier.sv
// PIN entry and verification front end for the ATM transaction controller;
// counts wrong attempts and retains the card once they run out.
module pin_verifier
  import atm_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned TRY_W     = 3
) (
  input  logic                      clock,
  input  logic                      cancel,
  input  logic                      card_insert,
  input  logic [DIGIT_W*DIGITS-1:0] stored_pin,
  input  logic                      key_valid,
  input  logic [DIGIT_W-1:0]        key_digit,
  input  logic                      key_enter,
  input  logic                      key_clear,
  output logic                      pin_ok,
  output logic                      pin_fail,
  output logic                      card_retain,
  output logic [TRY_W-1:0]          tries_left,
  output logic [2:0]                digit_count
);

  localparam int unsigned PIN_W = DIGIT_W * DIGITS;

  pv_state_t        r_state;
  logic [TRY_W-1:0] r_tries;
  logic             r_pin_ok;
  logic             r_pin_fail;
  logic             r_card_retain;

  logic [PIN_W-1:0] w_buffer;
  logic             w_full;
  logic             w_in_collect;
  logic             w_shift_en;
  logic             w_clr;
  logic             w_match;
  logic [TRY_W-1:0] w_tries_dec;

  // Keypad priority in COLLECT: clear, then enter, then digit.
  assign w_in_collect = (r_state == PV_COLLECT) && card_insert;
  assign w_shift_en   = w_in_collect && !key_clear && !key_enter && key_valid && is_bcd(key_digit);
  assign w_clr        = ((r_state == PV_IDLE) && card_insert) ||
                        (w_in_collect && key_clear) ||
                        (r_state == PV_FAIL);
  assign w_match      = w_full && (w_buffer == stored_pin);
  assign w_tries_dec  = r_tries - TRY_W'(1);

  pin_entry_buffer #(
    .DIGITS(DIGITS)
  ) u_entry (
    .i_clk        (clock),
    .i_rst        (cancel),
    .i_shift_en   (w_shift_en),
    .i_clr        (w_clr),
    .i_digit      (key_digit),
    .o_buffer     (w_buffer),
    .o_digit_count(digit_count),
    .o_full       (w_full)
  );

  always_ff @(posedge clock or posedge cancel) begin
    if (cancel) begin
      r_state       <= PV_IDLE;
      r_tries       <= TRY_W'(MAX_TRIES);
      r_pin_ok      <= 1'b0;
      r_pin_fail    <= 1'b0;
      r_card_retain <= 1'b0;
    end else begin
      r_pin_fail <= 1'b0;
      case (r_state)
        PV_IDLE: begin
          if (card_insert) begin
            r_state <= PV_COLLECT;
            r_tries <= TRY_W'(MAX_TRIES);
          end
        end
        PV_COLLECT: begin
          if (!card_insert)   r_state <= PV_IDLE;
          else if (key_clear) r_state <= PV_COLLECT;
          else if (key_enter) r_state <= PV_CHECK;
        end
        PV_CHECK: begin
          // Card removal abandons the attempt without charging a try.
          if (!card_insert) begin
            r_state <= PV_IDLE;
          end else if (w_match) begin
            r_state  <= PV_VERIFIED;
            r_pin_ok <= 1'b1;
          end else begin
            r_tries <= w_tries_dec;
            if (w_tries_dec == '0) begin
              r_state       <= PV_LOCKED;
              r_card_retain <= 1'b1;
            end else begin
              r_state    <= PV_FAIL;
              r_pin_fail <= 1'b1;
            end
          end
        end
        PV_FAIL: begin
          r_state <= card_insert ? PV_COLLECT : PV_IDLE;
        end
        PV_VERIFIED: begin
          if (!card_insert) begin
            r_state  <= PV_IDLE;
            r_pin_ok <= 1'b0;
          end
        end
        PV_LOCKED: begin
          r_state <= PV_LOCKED;
        end
        default: begin
          r_state       <= PV_IDLE;
          r_pin_ok      <= 1'b0;
          r_card_retain <= 1'b0;
        end
      endcase
    end
  end

  assign pin_ok      = r_pin_ok;
  assign pin_fail    = r_pin_fail;
  assign card_retain = r_card_retain;
  assign tries_left  = r_tries;

endmodule

// File: tb/tb_pin_verifier.sv
// Self-checking bench for pin_verifier: table of per-cycle stimulus with
// expected post-edge outputs, plus asynchronous cancel sequences.
module tb_pin_verifier;

  logic        clock;
  logic        cancel;
  logic        card_insert;
  logic [15:0] stored_pin;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        key_enter;
  logic        key_clear;
  logic        pin_ok;
  logic        pin_fail;
  logic        card_retain;
  logic [2:0]  tries_left;
  logic [2:0]  digit_count;

  pin_verifier #(
    .DIGITS   (4),
    .MAX_TRIES(3),
    .TRY_W    (3)
  ) dut (
    .clock      (clock),
    .cancel     (cancel),
    .card_insert(card_insert),
    .stored_pin (stored_pin),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .key_enter  (key_enter),
    .key_clear  (key_clear),
    .pin_ok     (pin_ok),
    .pin_fail   (pin_fail),
    .card_retain(card_retain),
    .tries_left (tries_left),
    .digit_count(digit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // exp packs {pin_ok, pin_fail, card_retain, tries_left[2:0], digit_count[2:0]}
  typedef struct {
    logic        ci;
    logic        kv;
    logic [3:0]  kd;
    logic        ke;
    logic        kc;
    logic [15:0] sp;
    logic [8:0]  exp;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] exp_q[$];
  logic [15:0] cur_sp;
  int         checks = 0;
  int         errors = 0;
  int         lock_idx;

  task automatic add(input logic ci, input logic kv, input logic [3:0] kd,
                     input logic ke, input logic kc,
                     input logic ok, input logic f, input logic r,
                     input logic [2:0] t, input logic [2:0] c);
    vec_t v;
    v.ci = ci; v.kv = kv; v.kd = kd; v.ke = ke; v.kc = kc; v.sp = cur_sp;
    v.exp = {ok, f, r, t, c};
    vecs.push_back(v);
  endtask

  function automatic logic [8:0] outs();
    return {pin_ok, pin_fail, card_retain, tries_left, digit_count};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got ok=%0b fail=%0b ret=%0b tries=%0d cnt=%0d, want ok=%0b fail=%0b ret=%0b tries=%0d cnt=%0d",
               name, got[8], got[7], got[6], got[5:3], got[2:0],
               want[8], want[7], want[6], want[5:3], want[2:0]);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    logic [8:0] want;
    @(negedge clock);
    card_insert = v.ci; key_valid = v.kv; key_digit = v.kd;
    key_enter = v.ke; key_clear = v.kc; stored_pin = v.sp;
    exp_q.push_back(v.exp);
    @(posedge clock);
    #1;
    want = exp_q.pop_front();
    check($sformatf("vec%0d", idx), outs(), want);
  endtask

  // Cancel is raised between edges; outputs must clear without a clock edge.
  task automatic async_cancel(input string name);
    @(negedge clock);
    card_insert = 1'b0; key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
    #2;
    cancel = 1'b1;
    #1;
    check(name, outs(), {1'b0, 1'b0, 1'b0, 3'd3, 3'd0});
    @(posedge clock);
    #1;
    check({name, "_hold"}, outs(), {1'b0, 1'b0, 1'b0, 3'd3, 3'd0});
    @(negedge clock);
    cancel = 1'b0;
  endtask

  initial begin
    cancel = 1'b1; card_insert = 1'b0; stored_pin = 16'h1234;
    key_valid = 1'b0; key_digit = 4'd0; key_enter = 1'b0; key_clear = 1'b0;
    cur_sp = 16'h1234;

    // Correct PIN
    add(1,0,0,0,0, 0,0,0,3,0);
    add(1,1,1,0,0, 0,0,0,3,1);
    add(1,1,2,0,0, 0,0,0,3,2);
    add(1,1,3,0,0, 0,0,0,3,3);
    add(1,1,4,0,0, 0,0,0,3,4);
    add(1,0,0,1,0, 0,0,0,3,4);
    add(1,0,0,0,0, 1,0,0,3,4);
    add(0,0,0,0,0, 0,0,0,3,4);
    // Wrong then right
    add(1,0,0,0,0, 0,0,0,3,0);
    add(1,1,1,0,0, 0,0,0,3,1);
    add(1,1,2,0,0, 0,0,0,3,2);
    add(1,1,3,0,0, 0,0,0,3,3);
    add(1,1,5,0,0, 0,0,0,3,4);
    add(1,0,0,1,0, 0,0,0,3,4);
    add(1,0,0,0,0, 0,1,0,2,4);
    add(1,0,0,0,0, 0,0,0,2,0);
    add(1,1,1,0,0, 0,0,0,2,1);
    add(1,1,2,0,0, 0,0,0,2,2);
    add(1,1,3,0,0, 0,0,0,2,3);
    add(1,1,4,0,0, 0,0,0,2,4);
    add(1,0,0,1,0, 0,0,0,2,4);
    add(1,0,0,0,0, 1,0,0,2,4);
    add(0,0,0,0,0, 0,0,0,2,4);
    // Lock-out after three wrong entries
    add(1,0,0,0,0, 0,0,0,3,0);
    for (int a = 0; a < 3; a++) begin
      for (int k = 0; k < 4; k++)
        add(1,1,9,0,0, 0,0,0,3'(3-a),3'(k+1));
      add(1,0,0,1,0, 0,0,0,3'(3-a),4);
      if (a < 2) begin
        add(1,0,0,0,0, 0,1,0,3'(2-a),4);
        add(1,0,0,0,0, 0,0,0,3'(2-a),0);
      end else begin
        add(1,0,0,0,0, 0,0,1,0,4);
      end
    end
    add(1,1,1,0,0, 0,0,1,0,4);
    add(1,0,0,1,0, 0,0,1,0,4);
    add(0,0,0,0,0, 0,0,1,0,4);
    lock_idx = vecs.size();
    // Short entry, overflow, non-BCD digit
    add(1,0,0,0,0, 0,0,0,3,0);
    add(1,1,1,0,0, 0,0,0,3,1);
    add(1,1,2,0,0, 0,0,0,3,2);
    add(1,0,0,1,0, 0,0,0,3,2);
    add(1,0,0,0,0, 0,1,0,2,2);
    add(1,0,0,0,0, 0,0,0,2,0);
    add(1,1,1,0,0, 0,0,0,2,1);
    add(1,1,2,0,0, 0,0,0,2,2);
    add(1,1,3,0,0, 0,0,0,2,3);
    add(1,1,4,0,0, 0,0,0,2,4);
    add(1,1,5,0,0, 0,0,0,2,4);
    add(1,1,4'hA,0,0, 0,0,0,2,4);
    add(1,0,0,1,0, 0,0,0,2,4);
    add(1,0,0,0,0, 1,0,0,2,4);
    add(0,0,0,0,0, 0,0,0,2,4);
    // Simultaneous strobes
    add(1,0,0,0,0, 0,0,0,3,0);
    add(1,1,1,0,0, 0,0,0,3,1);
    add(1,1,2,0,0, 0,0,0,3,2);
    add(1,1,7,0,1, 0,0,0,3,0);
    add(1,1,1,0,0, 0,0,0,3,1);
    add(1,1,2,0,0, 0,0,0,3,2);
    add(1,1,3,0,0, 0,0,0,3,3);
    add(1,1,4,1,0, 0,0,0,3,3);
    add(1,0,0,0,0, 0,1,0,2,3);
    add(1,0,0,0,0, 0,0,0,2,0);
    // Abort mid-entry and re-insert
    add(1,1,1,0,0, 0,0,0,2,1);
    add(1,1,2,0,0, 0,0,0,2,2);
    add(0,0,0,0,0, 0,0,0,2,2);
    add(0,0,0,0,0, 0,0,0,2,2);
    add(1,0,0,0,0, 0,0,0,3,0);
    // New card PIN, changed while idle/collecting
    cur_sp = 16'h9876;
    add(1,1,9,0,0, 0,0,0,3,1);
    add(1,1,8,0,0, 0,0,0,3,2);
    add(1,1,7,0,0, 0,0,0,3,3);
    add(1,1,6,0,0, 0,0,0,3,4);
    add(1,0,0,1,0, 0,0,0,3,4);
    add(1,0,0,0,0, 1,0,0,3,4);

    #2;
    check("reset", outs(), {1'b0, 1'b0, 1'b0, 3'd3, 3'd0});
    @(negedge clock);
    cancel = 1'b0;

    foreach (vecs[i]) begin
      if (i == lock_idx) async_cancel("cancel_locked");
      apply(vecs[i], i);
    end
    async_cancel("cancel_verified");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
